// File: rtl/fp_vector_checker.sv
// Walks a vector memory, calls an external unit per selected vector
// and counts result mismatches, with a per-call watchdog.
// Ports:
//   ap_clk, ap_rst_n                block clock, async active-low reset
//   ap_start/ap_done/ap_idle/ap_ready  block-level handshake
//   mode                            vector filter by operand signs
//   vec_addr/vec_ce/vec_a/b/z       vector memory port (1-cycle read)
//   dut_start/dut_a/dut_b/dut_sign  call port to the unit under test
//   dut_done/dut_result             completion and result from the unit
//   ap_return                       saturating mismatch count
//   fail_idx/fail_valid             first failing vector index
//   timeout_seen                    some call hit the watchdog
module fp_vector_checker #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 22,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              vec_ce,
  input  logic [DATA_W-1:0] vec_a,
  input  logic [DATA_W-1:0] vec_b,
  input  logic [DATA_W-1:0] vec_z,
  output logic              dut_start,
  output logic [DATA_W-1:0] dut_a,
  output logic [DATA_W-1:0] dut_b,
  output logic              dut_sign,
  input  logic              dut_done,
  input  logic [DATA_W-1:0] dut_result,
  output logic [CNT_W-1:0]  ap_return,
  output logic [ADDR_W-1:0] fail_idx,
  output logic              fail_valid,
  output logic              timeout_seen
);

  // Watchdog only has to count to TIMEOUT-1.
  localparam int WD_W =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH);
  localparam logic [WD_W-1:0] WD_MAX =
    WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_FETCH = 6'b000010,
    S_LATCH = 6'b000100,
    S_CALL  = 6'b001000,
    S_WAIT  = 6'b010000,
    S_CHECK = 6'b100000
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] idx;
  logic [WD_W-1:0]   wd;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] f_idx;
  logic              f_val;
  logic              to_seen;
  logic              to_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] z_q;
  logic [DATA_W-1:0] res_q;

  logic at_end;
  logic sel;
  logic sa;
  logic sb;
  logic wd_hit;
  logic mism;

  assign at_end = (idx == LAST);
  assign sa     = vec_a[DATA_W-1];
  assign sb     = vec_b[DATA_W-1];
  assign wd_hit = (wd == WD_MAX);
  assign mism   = to_q | (res_q != z_q);

  always_comb begin
    sel = 1'b0;
    unique case (mode)
      2'd0:    sel = 1'b1;
      2'd1:    sel = (sa != sb);
      2'd2:    sel = (sa == sb);
      default: sel = 1'b0;
    endcase
  end

  assign vec_addr     = idx;
  assign dut_a        = a_q;
  assign dut_b        = b_q;
  assign dut_sign     = a_q[DATA_W-1];
  assign ap_return    = cnt;
  assign fail_idx     = f_idx;
  assign fail_valid   = f_val;
  assign timeout_seen = to_seen;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= S_IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ap_done   = 1'b0;
    ap_ready  = 1'b0;
    ap_idle   = 1'b0;
    vec_ce    = 1'b0;
    dut_start = 1'b0;
    unique case (1'b1)
      (state == S_IDLE): begin
        ap_idle = 1'b1;
        if (ap_start) state_nx = S_FETCH;
      end
      (state == S_FETCH): begin
        if (at_end) begin
          ap_done  = 1'b1;
          ap_ready = 1'b1;
          state_nx = S_IDLE;
        end else begin
          vec_ce   = 1'b1;
          state_nx = S_LATCH;
        end
      end
      (state == S_LATCH): begin
        state_nx = sel ? S_CALL : S_FETCH;
      end
      (state == S_CALL): begin
        dut_start = 1'b1;
        state_nx  = S_WAIT;
      end
      (state == S_WAIT): begin
        if (dut_done || wd_hit)
          state_nx = S_CHECK;
      end
      (state == S_CHECK): begin
        state_nx = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      idx     <= '0;
      wd      <= '0;
      cnt     <= '0;
      f_idx   <= '0;
      f_val   <= 1'b0;
      to_seen <= 1'b0;
      to_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      res_q   <= '0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (ap_start) begin
            idx     <= '0;
            cnt     <= '0;
            f_idx   <= '0;
            f_val   <= 1'b0;
            to_seen <= 1'b0;
          end
        end
        (state == S_LATCH): begin
          a_q <= vec_a;
          b_q <= vec_b;
          z_q <= vec_z;
          if (!sel) idx <= idx + 1'b1;
        end
        (state == S_CALL): begin
          wd   <= '0;
          to_q <= 1'b0;
        end
        (state == S_WAIT): begin
          // A completion on the last watchdog cycle still counts.
          if (dut_done) begin
            res_q <= dut_result;
          end else if (wd_hit) begin
            to_q    <= 1'b1;
            to_seen <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        (state == S_CHECK): begin
          if (mism) begin
            if (cnt != CNT_MAX)
              cnt <= cnt + 1'b1;
            if (!f_val) begin
              f_idx <= idx;
              f_val <= 1'b1;
            end
          end
          idx <= idx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
